// File: rtl/recorder_pkg.sv
// Shared sizing for the audio recorder: default sample width, memory depth
// and the address width derived from that depth.
package recorder_pkg;

    localparam int SAMPLE_WIDTH_DEF = 8;
    localparam int DEPTH_DEF        = 65536;

    function automatic int addr_width(input int depth);
        return $clog2(depth);
    endfunction

    localparam int ADDR_WIDTH_DEF = addr_width(DEPTH_DEF);

endpackage

// File: rtl/recorder_bram.sv
// Simple dual-port sample memory: synchronous write port, registered read port.
// No reset, so it maps onto block RAM.
module recorder_bram #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 65536,
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_addr] <= wr_data;
        if (rd_en)
            rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/recorder.sv
// Record/loop-playback audio recorder: pointer control, record edge detect and
// the two-stage playback output pipeline around a block-RAM sample store.
module recorder
    import recorder_pkg::*;
#(
    parameter int SAMPLE_WIDTH = SAMPLE_WIDTH_DEF,
    parameter int DEPTH        = DEPTH_DEF
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic                    record_in,
    input  logic                    audio_valid_in,
    input  logic [SAMPLE_WIDTH-1:0] audio_in,
    output logic [SAMPLE_WIDTH-1:0] single_out,
    output logic                    finish
);

    localparam int AW = addr_width(DEPTH);
    localparam logic [AW:0] DEPTH_P = (AW+1)'(DEPTH);

    logic [AW:0] wr_ptr, rd_ptr, len;
    logic [AW:0] wr_eff, rd_eff, rd_next;
    logic        record_q, rise, fall;
    logic        wr_en, rd_en, last_p0;
    logic        vld_p1, last_p1, vld_p2, last_p2;
    logic [SAMPLE_WIDTH-1:0] rd_data;

    // Stage 0: edge detect and pointer selection; an edge overrides the
    // stored pointer so a strobe on the same cycle uses the fresh pointer.
    always_comb begin
        rise    = record_in & ~record_q;
        fall    = ~record_in & record_q;
        wr_eff  = rise ? '0 : wr_ptr;
        rd_eff  = fall ? '0 : rd_ptr;
        wr_en   = ~rst_in & record_in & audio_valid_in & (wr_eff < DEPTH_P);
        rd_en   = ~rst_in & ~record_in & audio_valid_in & (len != '0);
        last_p0 = (rd_eff == len - 1'b1);
        rd_next = last_p0 ? '0 : rd_eff + 1'b1;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            record_q   <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            len        <= '0;
            vld_p1     <= 1'b0;
            last_p1    <= 1'b0;
            vld_p2     <= 1'b0;
            last_p2    <= 1'b0;
            single_out <= '0;
            finish     <= 1'b0;
        end else begin
            record_q <= record_in;
            if (rise) begin
                wr_ptr <= '0;
                len    <= '0;
            end
            if (wr_en) begin
                wr_ptr <= wr_eff + 1'b1;
                len    <= wr_eff + 1'b1;
            end
            if (fall)
                rd_ptr <= '0;
            if (rd_en)
                rd_ptr <= rd_next;

            // Stage 1: read issued, RAM output register loading
            vld_p1  <= rd_en;
            last_p1 <= rd_en & last_p0;

            // Stage 2: RAM data valid, aligned with its last-sample flag
            vld_p2  <= vld_p1;
            last_p2 <= last_p1;

            finish <= 1'b0;
            if (vld_p2 && !record_in) begin
                single_out <= rd_data;
                finish     <= last_p2;
            end
        end
    end

    recorder_bram #(
        .DATA_W (SAMPLE_WIDTH),
        .DEPTH  (DEPTH),
        .ADDR_W (AW)
    ) u_bram (
        .clk     (clk_in),
        .wr_en   (wr_en),
        .wr_addr (wr_eff[AW-1:0]),
        .wr_data (audio_in),
        .rd_en   (rd_en),
        .rd_addr (rd_eff[AW-1:0]),
        .rd_data (rd_data)
    );

endmodule

// File: tb/tb_recorder.sv
// Directed bench for the recorder: a 16K-deep instance for record/loop/reset
// scenarios and a 64-deep instance for the overflow-and-wrap scenario.
module tb_recorder;

    logic       clk = 1'b0;
    logic       rst;
    logic       record, valid;
    logic [7:0] audio;
    logic [7:0] single_out;
    logic       finish;
    logic       s_record, s_valid;
    logic [7:0] s_audio;
    logic [7:0] s_out;
    logic       s_finish;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    recorder #(.SAMPLE_WIDTH(8), .DEPTH(16384)) dut (
        .clk_in         (clk),
        .rst_in         (rst),
        .record_in      (record),
        .audio_valid_in (valid),
        .audio_in       (audio),
        .single_out     (single_out),
        .finish         (finish)
    );

    recorder #(.SAMPLE_WIDTH(8), .DEPTH(64)) dut_small (
        .clk_in         (clk),
        .rst_in         (rst),
        .record_in      (s_record),
        .audio_valid_in (s_valid),
        .audio_in       (s_audio),
        .single_out     (s_out),
        .finish         (s_finish)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One playback strobe, then gap-1 idle cycles; output checked 2 cycles on.
    task automatic play(input bit sel, input int gap, input logic [7:0] exp_val,
                        input logic [7:0] hold_val, input logic exp_fin, input string tag);
        if (sel) s_valid = 1'b1; else valid = 1'b1;
        tick();
        s_valid = 1'b0;
        valid   = 1'b0;
        tick();
        if (gap >= 7) begin
            chk({tag, "_hold"}, sel ? s_out : single_out, hold_val);
            chk({tag, "_hold_fin"}, sel ? s_finish : finish, 1'b0);
        end
        tick();
        chk({tag, "_out"}, sel ? s_out : single_out, exp_val);
        chk({tag, "_fin"}, sel ? s_finish : finish, exp_fin);
        for (int k = 3; k < gap; k++) begin
            tick();
            if (k == 3)
                chk({tag, "_fin_drop"}, sel ? s_finish : finish, 1'b0);
        end
    endtask

    function automatic logic [7:0] small_val(input int i);
        return 8'((i * 3 + 1) & 255);
    endfunction

    initial begin
        logic [7:0] prev;
        rst = 1'b1; record = 1'b0; valid = 1'b0; audio = '0;
        s_record = 1'b0; s_valid = 1'b0; s_audio = '0;
        repeat (3) tick();
        chk("reset_out", single_out, 8'd0);
        chk("reset_fin", finish, 1'b0);
        chk("reset_small_out", s_out, 8'd0);
        rst = 1'b0;
        tick();

        // Record 10000 samples; record rises on the same cycle as sample 0.
        record = 1'b1;
        for (int i = 0; i < 10000; i++) begin
            valid = 1'b1;
            audio = 8'(i & 255);
            tick();
            chk("rec_out", single_out, 8'd0);
            chk("rec_fin", finish, 1'b0);
        end
        valid = 1'b0;
        tick();

        // Looped playback; record falls on the cycle of the first strobe.
        record = 1'b0;
        prev   = 8'd0;
        for (int i = 0; i <= 10001; i++) begin
            int idx;
            idx = i % 10000;
            play(1'b0, (i < 300 || i >= 9990) ? 7 : 3, 8'(idx & 255), prev,
                 i == 9999, "play");
            prev = 8'(idx & 255);
        end
        chk("play_last", single_out, 8'd1);

        // Reset held across 10000 strobes with record toggling.
        rst = 1'b1;
        for (int i = 0; i < 10000; i++) begin
            valid  = 1'b1;
            audio  = 8'($urandom_range(255, 1));
            record = (i >= 2000 && i < 4000);
            tick();
            chk("rst_out", single_out, 8'd0);
            chk("rst_fin", finish, 1'b0);
        end
        record = 1'b0;
        rst    = 1'b0;

        // Nothing recorded since reset: strobes must be ignored.
        for (int i = 0; i < 10000; i++) begin
            valid = 1'b1;
            tick();
            chk("empty_out", single_out, 8'd0);
            chk("empty_fin", finish, 1'b0);
        end
        valid = 1'b0;
        tick();

        // Small instance: DEPTH+5 samples, the last five dropped.
        s_record = 1'b1;
        for (int i = 0; i < 69; i++) begin
            s_valid = 1'b1;
            s_audio = small_val(i);
            tick();
            chk("srec_out", s_out, 8'd0);
        end
        s_valid = 1'b0;
        tick();
        s_record = 1'b0;
        prev     = 8'd0;
        for (int i = 0; i < 66; i++) begin
            play(1'b1, 7, small_val(i % 64), prev, i == 63, "splay");
            prev = small_val(i % 64);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
